// File: rtl/dma_dev_port.sv
// dma_dev_port: device-side endpoint of the DMA rqst/dev_ack/dma_ack/end_flag handshake.
// Owns a local word buffer. It streams the buffer out for DMA writes and captures
// into it for DMA reads, then reports done/error/overrun/xfer_count.
module dma_dev_port #(
    parameter int unsigned ADD_LEN   = 16,
    parameter int unsigned DATA_LEN  = 16,
    parameter int unsigned BUF_DEPTH = 5,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_start,
    input  logic                 cmd_rd_wr,
    input  logic [ADD_LEN-1:0]   cmd_num_words,
    input  logic [ADD_LEN:0]     cmd_addr,
    input  logic                 dev_stall,
    input  logic                 buf_wr_en,
    input  logic [BUF_DEPTH-1:0] buf_addr,
    input  logic [DATA_LEN-1:0]  buf_wdata,
    input  logic [BUF_DEPTH-1:0] buf_rd_addr,
    output logic [DATA_LEN-1:0]  buf_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 overrun,
    output logic [ADD_LEN-1:0]   xfer_count,
    output logic [ADD_LEN-1:0]   num_words,
    output logic [ADD_LEN:0]     start_addr,
    output logic                 rd_wr,
    output logic                 rqst,
    output logic                 dev_ack,
    output logic [DATA_LEN-1:0]  dev_in,
    input  logic                 dma_ack,
    input  logic [DATA_LEN-1:0]  dev_out,
    input  logic                 end_flag
);

    localparam int unsigned TMO_W     = $clog2(TIMEOUT) + 1;
    localparam int unsigned BUF_WORDS = 1 << BUF_DEPTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        XFER_RD = 3'd2,
        XFER_WR = 3'd3,
        FINISH  = 3'd4,
        ABORT   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADD_LEN-1:0]    r_num_words;
    logic [ADD_LEN-1:0]    r_xfer_count;
    logic [ADD_LEN:0]      r_start_addr;
    logic                  r_rd_wr;
    logic                  r_error;
    logic                  r_overrun;
    logic [TMO_W-1:0]      r_tmo;
    logic [DATA_LEN-1:0]   r_buf [BUF_WORDS];

    logic                  w_in_xfer;
    logic                  w_cnt_lt;
    logic                  w_activity;
    logic                  w_tmo_hit;
    logic                  w_count_en;
    logic                  w_overrun_set;
    logic                  w_rd_store;
    logic [ADD_LEN-1:0]    w_cnt_nxt;
    logic [BUF_DEPTH-1:0]  w_buf_idx;
    logic                  w_dev_ack;

    assign w_in_xfer     = (r_state == XFER_RD) || (r_state == XFER_WR);
    assign w_cnt_lt      = (r_xfer_count < r_num_words);
    assign w_activity    = dma_ack || end_flag;
    assign w_tmo_hit     = !w_activity && (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_rd_store    = (r_state == XFER_RD) && dma_ack && w_cnt_lt;
    assign w_overrun_set = (r_state == XFER_RD) && dma_ack && !w_cnt_lt;
    assign w_count_en    = ((r_state == XFER_WR) && dma_ack) || w_rd_store;
    assign w_cnt_nxt     = w_count_en ? (r_xfer_count + ADD_LEN'(1)) : r_xfer_count;
    assign w_buf_idx     = r_xfer_count[BUF_DEPTH-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode
    always_comb begin
        w_state_nxt = r_state;
        w_dev_ack   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_start) w_state_nxt = REQ;
            end
            REQ: begin
                w_state_nxt = r_rd_wr ? XFER_RD : XFER_WR;
            end
            XFER_RD, XFER_WR: begin
                // Write side stops offering data once the programmed count is reached
                w_dev_ack = !dev_stall && ((r_state == XFER_RD) || w_cnt_lt);
                if (end_flag)       w_state_nxt = FINISH;
                else if (w_tmo_hit) w_state_nxt = ABORT;
            end
            FINISH, ABORT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Command latch, transfer counter, timeout and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_num_words  <= '0;
            r_xfer_count <= '0;
            r_start_addr <= '0;
            r_rd_wr      <= 1'b0;
            r_error      <= 1'b0;
            r_overrun    <= 1'b0;
            r_tmo        <= '0;
        end else if ((r_state == IDLE) && cmd_start) begin
            r_num_words  <= cmd_num_words;
            r_start_addr <= cmd_addr;
            r_rd_wr      <= cmd_rd_wr;
            r_xfer_count <= '0;
            r_error      <= 1'b0;
            r_overrun    <= 1'b0;
            r_tmo        <= '0;
        end else if (w_in_xfer) begin
            r_xfer_count <= w_cnt_nxt;
            if (w_overrun_set) r_overrun <= 1'b1;
            r_tmo <= w_activity ? '0 : (r_tmo + TMO_W'(1));
            // Error is resolved on the closing edge so it is valid together with done
            if (end_flag)       r_error <= (w_cnt_nxt != r_num_words);
            else if (w_tmo_hit) r_error <= 1'b1;
        end
    end

    // Local buffer: host preload while idle, DMA capture during reads
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && buf_wr_en) begin
            r_buf[buf_addr] <= buf_wdata;
        end else if (w_rd_store) begin
            r_buf[w_buf_idx] <= dev_out;
        end
    end

    assign busy       = (r_state != IDLE);
    assign done       = (r_state == FINISH) || (r_state == ABORT);
    assign rqst       = (r_state == REQ);
    assign dev_ack    = w_dev_ack;
    assign dev_in     = r_buf[w_buf_idx];
    assign buf_rdata  = r_buf[buf_rd_addr];
    assign error      = r_error;
    assign overrun    = r_overrun;
    assign xfer_count = r_xfer_count;
    assign num_words  = r_num_words;
    assign start_addr = r_start_addr;
    assign rd_wr      = r_rd_wr;

endmodule

// File: tb/tb_dma_dev_port.sv
// Self-checking bench for dma_dev_port; a small DMA-controller model drives the handshake.
module tb_dma_dev_port;

    localparam int unsigned ADD_LEN   = 16;
    localparam int unsigned DATA_LEN  = 16;
    localparam int unsigned BUF_DEPTH = 5;
    localparam int unsigned TIMEOUT   = 1024;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 cmd_start = 1'b0;
    logic                 cmd_rd_wr = 1'b0;
    logic [ADD_LEN-1:0]   cmd_num_words = '0;
    logic [ADD_LEN:0]     cmd_addr = '0;
    logic                 dev_stall = 1'b0;
    logic                 buf_wr_en = 1'b0;
    logic [BUF_DEPTH-1:0] buf_addr = '0;
    logic [DATA_LEN-1:0]  buf_wdata = '0;
    logic [BUF_DEPTH-1:0] buf_rd_addr = '0;
    logic [DATA_LEN-1:0]  buf_rdata;
    logic                 busy, done, error, overrun, rd_wr, rqst, dev_ack;
    logic [ADD_LEN-1:0]   xfer_count, num_words;
    logic [ADD_LEN:0]     start_addr;
    logic [DATA_LEN-1:0]  dev_in;
    logic                 dma_ack = 1'b0;
    logic [DATA_LEN-1:0]  dev_out = '0;
    logic                 end_flag = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_LEN-1:0] sb_q [$];

    always #5 clk = ~clk;

    dma_dev_port #(
        .ADD_LEN(ADD_LEN), .DATA_LEN(DATA_LEN), .BUF_DEPTH(BUF_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_rd_wr(cmd_rd_wr),
        .cmd_num_words(cmd_num_words), .cmd_addr(cmd_addr), .dev_stall(dev_stall),
        .buf_wr_en(buf_wr_en), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .buf_rd_addr(buf_rd_addr), .buf_rdata(buf_rdata), .busy(busy), .done(done),
        .error(error), .overrun(overrun), .xfer_count(xfer_count), .num_words(num_words),
        .start_addr(start_addr), .rd_wr(rd_wr), .rqst(rqst), .dev_ack(dev_ack),
        .dev_in(dev_in), .dma_ack(dma_ack), .dev_out(dev_out), .end_flag(end_flag)
    );

    // Stimulus helpers: all are entered and left at a falling edge
    task automatic preload(input int a, input logic [DATA_LEN-1:0] d);
        buf_wr_en = 1'b1;
        buf_addr  = BUF_DEPTH'(a);
        buf_wdata = d;
        @(negedge clk);
        buf_wr_en = 1'b0;
    endtask

    task automatic start_cmd(input logic rw, input int num, input logic [ADD_LEN:0] addr);
        cmd_start     = 1'b1;
        cmd_rd_wr     = rw;
        cmd_num_words = ADD_LEN'(num);
        cmd_addr      = addr;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic pulse_end();
        dma_ack  = 1'b0;
        end_flag = 1'b1;
        @(negedge clk);
        end_flag = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rqst, dev_ack, busy, done, error, overrun, rd_wr} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 0000000", {rqst, dev_ack, busy, done, error, overrun, rd_wr});
        end
        n_checks++;
        if (xfer_count !== '0 || num_words !== '0 || start_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: got cnt=%0h num=%0h addr=%0h required 0", xfer_count, num_words, start_addr);
        end
    endtask

    task automatic test_dma_write();
        logic prev_ack;
        logic [DATA_LEN-1:0] exp;
        int sent = 0;
        for (int i = 0; i < 4; i++) begin
            preload(i, DATA_LEN'(16'h1111 * (i + 1)));
            sb_q.push_back(DATA_LEN'(16'h1111 * (i + 1)));
        end
        preload(10, 16'h0A0A);
        start_cmd(1'b0, 4, 17'h0200);
        n_checks++;
        if (rqst !== 1'b1 || busy !== 1'b1 || dev_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_req: got rqst=%b busy=%b ack=%b required 1 1 0", rqst, busy, dev_ack);
        end
        n_checks++;
        if (num_words !== 16'd4 || start_addr !== 17'h0200 || rd_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_latch: got num=%0h addr=%0h rw=%b required 4 200 0", num_words, start_addr, rd_wr);
        end
        // Attempted preload while busy must be ignored
        buf_wr_en = 1'b1; buf_addr = 5'd10; buf_wdata = 16'hDEAD;
        @(negedge clk);
        buf_wr_en = 1'b0;
        n_checks++;
        if (rqst !== 1'b0 || dev_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_rqst_pulse: got rqst=%b ack=%b required 0 1", rqst, dev_ack);
        end
        prev_ack = dev_ack;
        for (int c = 0; c < 50 && sent < 4; c++) begin
            if (prev_ack) begin
                exp = sb_q.pop_front();
                n_checks++;
                if (dev_in !== exp) begin
                    n_fail++;
                    $display("FAIL wr_data%0d: got %0h required %0h", sent, dev_in, exp);
                end
                dma_ack = 1'b1;
                sent++;
            end
            @(negedge clk);
            dma_ack  = 1'b0;
            prev_ack = dev_ack;
        end
        n_checks++;
        if (sent != 4 || dev_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_strobes: got sent=%0d ack=%b required 4 0", sent, dev_ack);
        end
        pulse_end();
        n_checks++;
        if (done !== 1'b1 || xfer_count !== 16'd4 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done: got done=%b cnt=%0d err=%b required 1 4 0", done, xfer_count, error);
        end
        @(negedge clk);
        buf_rd_addr = 5'd10;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || buf_rdata !== 16'h0A0A) begin
            n_fail++;
            $display("FAIL wr_after: got busy=%b done=%b buf10=%0h required 0 0 a0a", busy, done, buf_rdata);
        end
    endtask

    task automatic test_dma_read_stall();
        logic prev_ack = 1'b0;
        logic [DATA_LEN-1:0] exp;
        int sent = 0;
        int cyc = 0;
        sb_q.delete();
        start_cmd(1'b1, 8, 17'h0400);
        @(negedge clk);
        while (sent < 8 && cyc < 100) begin
            dev_stall = ((cyc / 3) % 2) == 1;
            if (prev_ack) begin
                dma_ack = 1'b1;
                dev_out = DATA_LEN'(16'hC000 + sent);
                sb_q.push_back(dev_out);
                sent++;
            end else begin
                dma_ack = 1'b0;
            end
            #1 prev_ack = dev_ack;
            @(negedge clk);
            cyc++;
        end
        dma_ack = 1'b0;
        dev_stall = 1'b0;
        pulse_end();
        n_checks++;
        if (sent != 8 || done !== 1'b1 || xfer_count !== 16'd8 || error !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_done: got sent=%0d done=%b cnt=%0d err=%b ovr=%b required 8 1 8 0 0",
                     sent, done, xfer_count, error, overrun);
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            buf_rd_addr = BUF_DEPTH'(i);
            exp = sb_q.pop_front();
            #1;
            n_checks++;
            if (buf_rdata !== exp) begin
                n_fail++;
                $display("FAIL rd_buf%0d: got %0h required %0h", i, buf_rdata, exp);
            end
        end
    endtask

    task automatic test_zero_words();
        int acks = 0;
        @(negedge clk);
        start_cmd(1'b0, 0, 17'h0010);
        n_checks++;
        if (rqst !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_rqst: got %b required 1", rqst);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (dev_ack === 1'b1) acks++;
        end
        n_checks++;
        if (acks != 0) begin
            n_fail++;
            $display("FAIL zero_ack: got %0d dev_ack cycles required 0", acks);
        end
        pulse_end();
        n_checks++;
        if (done !== 1'b1 || xfer_count !== 16'd0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: got done=%b cnt=%0d err=%b required 1 0 0", done, xfer_count, error);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap_40();
        logic [DATA_LEN-1:0] exp;
        sb_q.delete();
        start_cmd(1'b1, 40, 17'h0800);
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            dma_ack = 1'b1;
            dev_out = DATA_LEN'(16'hA000 + k);
            if (k >= 32) sb_q.push_back(dev_out);
            @(negedge clk);
        end
        pulse_end();
        n_checks++;
        if (done !== 1'b1 || xfer_count !== 16'd40 || error !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_done: got done=%b cnt=%0d err=%b ovr=%b required 1 40 0 0",
                     done, xfer_count, error, overrun);
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            buf_rd_addr = BUF_DEPTH'(i);
            exp = sb_q.pop_front();
            #1;
            n_checks++;
            if (buf_rdata !== exp) begin
                n_fail++;
                $display("FAIL wrap_buf%0d: got %0h required %0h", i, buf_rdata, exp);
            end
        end
        buf_rd_addr = 5'd8;
        #1;
        n_checks++;
        if (buf_rdata !== 16'hA008) begin
            n_fail++;
            $display("FAIL wrap_buf8: got %0h required a008", buf_rdata);
        end
    endtask

    task automatic test_overrun_error();
        logic [DATA_LEN-1:0] exp;
        sb_q.delete();
        @(negedge clk);
        preload(3, 16'hBEEF);
        start_cmd(1'b1, 3, 17'h0100);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            dma_ack = 1'b1;
            dev_out = DATA_LEN'(16'h5000 + k);
            if (k < 3) sb_q.push_back(dev_out);
            @(negedge clk);
        end
        pulse_end();
        n_checks++;
        if (done !== 1'b1 || overrun !== 1'b1 || error !== 1'b0 || xfer_count !== 16'd3) begin
            n_fail++;
            $display("FAIL ovr_done: got done=%b ovr=%b err=%b cnt=%0d required 1 1 0 3",
                     done, overrun, error, xfer_count);
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            buf_rd_addr = BUF_DEPTH'(i);
            exp = (i < 3) ? sb_q.pop_front() : 16'hBEEF;
            #1;
            n_checks++;
            if (buf_rdata !== exp) begin
                n_fail++;
                $display("FAIL ovr_buf%0d: got %0h required %0h", i, buf_rdata, exp);
            end
        end
        @(negedge clk);
        start_cmd(1'b1, 3, 17'h0100);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            dma_ack = 1'b1;
            dev_out = DATA_LEN'(16'h6000 + k);
            @(negedge clk);
        end
        pulse_end();
        n_checks++;
        if (done !== 1'b1 || error !== 1'b1 || overrun !== 1'b0 || xfer_count !== 16'd2) begin
            n_fail++;
            $display("FAIL short_done: got done=%b err=%b ovr=%b cnt=%0d required 1 1 0 2",
                     done, error, overrun, xfer_count);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout_and_reset();
        int n = 0;
        start_cmd(1'b0, 2, 17'h0300);
        @(negedge clk);
        while (done !== 1'b1 && n < int'(TIMEOUT) + 20) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (done !== 1'b1 || n != int'(TIMEOUT)) begin
            n_fail++;
            $display("FAIL tmo_latency: got done=%b after %0d cycles required 1 after %0d", done, n, TIMEOUT);
        end
        n_checks++;
        if (error !== 1'b1 || dev_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_abort: got err=%b ack=%b required 1 0", error, dev_ack);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_after: got busy=%b done=%b err=%b required 0 0 1", busy, done, error);
        end
        // Reset in the middle of a read transfer
        start_cmd(1'b1, 4, 17'h0500);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            dma_ack = 1'b1;
            dev_out = DATA_LEN'(16'h7000 + k);
            @(negedge clk);
        end
        n_checks++;
        if (xfer_count !== 16'd2 || dev_ack !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_state: got cnt=%0d ack=%b busy=%b required 2 1 1", xfer_count, dev_ack, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rqst, dev_ack, busy, done, error, overrun, rd_wr} !== 7'b0 ||
            xfer_count !== '0 || num_words !== '0 || start_addr !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got flags=%b cnt=%0h num=%0h addr=%0h required all 0",
                     {rqst, dev_ack, busy, done, error, overrun, rd_wr}, xfer_count, num_words, start_addr);
        end
        dma_ack = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dma_write();
        test_dma_read_stall();
        test_zero_words();
        test_wrap_40();
        test_overrun_error();
        test_timeout_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
